fetch_unit: RTL and testbench
=============================

# fetch_unit

- Front-end instruction fetch stage of the CPU; feeds the decode/execute stage one instruction per cycle.
- Owns the program counter and issues sequential word-aligned requests to a synchronous instruction memory.
- Buffers returned instructions with their PCs in a small FIFO and presents them through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight work.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request, one word per asserted cycle.
- imem_addr  output  32  byte address of request; bits [1:0] always 0.
- imem_rdata  input  32  instruction word; valid exactly one cycle after its request.
- redirect_valid  input  1  load new PC and flush.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- out_valid  output  1  out_instr/out_pc hold a valid instruction.
- out_instr  output  32  instruction word to decode.
- out_pc  output  32  address of out_instr.
- out_ready  input  1  decode accepts the instruction this cycle.

## Operation

- State:
  - pc: next fetch address.
  - inflight: 1 bit; a request was issued last cycle.
  - kill: 1 bit; the in-flight response must be dropped.
  - FIFO: count in 0..FIFO_DEPTH.
- Request rule: imem_req = !rst && !redirect_valid && (count + inflight < FIFO_DEPTH). On request, imem_addr = pc and pc ← pc + 4.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Response: when inflight && !kill, push {imem_rdata, address of that request} into the FIFO. The credit rule guarantees space, so no overflow is possible.
- Output: out_valid = (count != 0). Head entry drives out_instr/out_pc. Pop when out_valid && out_ready.
- Push and pop in the same cycle: count unchanged; entry order preserved.
- Redirect (highest priority):
  - Same cycle: FIFO cleared (count ← 0), pc ← {redirect_pc[31:2], 2'b00}, no request issued.
  - kill ← inflight, so a response arriving next cycle is discarded.
  - A pop in that same cycle is still honoured by the consumer; the entry is gone afterwards either way.
- Back-to-back redirects: the last one wins; each re-clears the FIFO.
- Reset mid-operation: all state returns to reset values on the next edge; any response arriving after reset is discarded (inflight, kill cleared).

## Timing

- Reset values: pc = RESET_PC, inflight = 0, kill = 0, count = 0, imem_req = 0, imem_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0.
- First request in cycle R, the first cycle with rst low. Its instruction is pushed at the end of R+1; out_valid rises in R+2.
- Request-to-output latency is 2 cycles; there is no bypass path.
- Throughput is 1 instruction/cycle sustained while out_ready stays high.
- Redirect asserted in cycle T:
  - First new request in T+1 at the target.
  - First target instruction valid at the output in T+3.
- Stall (out_ready low): requests stop once count + inflight reaches FIFO_DEPTH. Output holds stable until accepted.

## Configuration

- FETCH_PERF_EN defined: adds two output ports, each 32-bit, cleared on rst and wrapping modulo 2^32:
  - perf_fetched: +1 per output handshake.
  - perf_stall: +1 per cycle with out_valid && !out_ready.
- FETCH_PERF_EN undefined: ports and counters are absent; all other behaviour is identical.

## Structure

- Shared package cpu_pkg holds XLEN = 32, INSTR_W = 32, PC_STEP = 4, and the fetch-entry struct {instr, pc}.
- One sub-module: fetch_fifo, a synchronous FIFO parameterised by depth and entry type, with flush, push, pop and count.
- Credit logic, PC and kill tracking stay in fetch_unit.

## Test plan

- Reset release, out_ready = 1, memory returns word = address:
  - out_pc sequence 0, 4, 8, 12 on consecutive cycles starting cycle R+2.
  - out_instr equals out_pc each cycle.
- out_ready = 0 from reset:
  - Exactly 4 requests issued (0..12), then imem_req stays 0.
  - Raising out_ready drains 0, 4, 8, 12, then fetching resumes at 16.
- Redirect to 32'h0000_0103 while the FIFO holds entries and a request is in flight:
  - FIFO is emptied and the in-flight word is never output.
  - Next request addr = 32'h100; out_pc = 32'h100 three cycles after the redirect.
- RESET_PC = 32'hFFFF_FFF8, free-running: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst asserted for 1 cycle mid-stream with a full FIFO:
  - Next cycle out_valid = 0 and pc = RESET_PC.
  - No pre-reset instruction ever appears at the output.
- FETCH_PERF_EN build: 10 accepted instructions and 3 stall cycles give perf_fetched = 10, perf_stall = 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC step and the fetch buffer entry.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low target bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory request/response, redirect input and
// the valid/ready instruction stream towards decode.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;
    logic               out_ready;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched entries; flush empties it and overrides push/pop.
module fetch_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = logic
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   push_data,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_pop;

    assign do_pop = pop && (count_q != '0);
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited request issue, response buffer and redirect flush.
// Defining FETCH_PERF_EN adds the perf_fetched / perf_stall counter ports.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d, kill_q, kill_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            req, push, pop;
    fetch_entry_t    push_entry, head;

    // Buffered plus in-flight words never exceed the FIFO, so a push always has room.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign req       = !rst && !bus.redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign push      = inflight_q && !kill_q;
    assign pop       = bus.out_valid && bus.out_ready;
    assign push_entry = '{instr: bus.imem_rdata, pc: req_pc_q};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = bus.out_valid ? head.instr : '0;
    assign bus.out_pc    = bus.out_valid ? head.pc    : '0;

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = req;
        kill_d     = bus.redirect_valid && inflight_q;
        if (bus.redirect_valid) begin
            pc_d = align_pc(bus.redirect_pc);
        end else if (req) begin
            pc_d     = pc_q + PC_STEP;
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_stall_d   = perf_stall_q + 32'(bus.out_valid && !bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + random bench for fetch_unit; a stream-level model predicts request
// credit, output validity and the expected PC/instruction order.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus0();
    fetch_unit_if bus1();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched0, perf_stall0, perf_fetched1, perf_stall1;
`endif

    fetch_unit #(.RESET_PC(RPC0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
`ifdef FETCH_PERF_EN
        , .perf_fetched (perf_fetched0), .perf_stall (perf_stall0)
`endif
    );

    fetch_unit #(.RESET_PC(RPC1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
`ifdef FETCH_PERF_EN
        , .perf_fetched (perf_fetched1), .perf_stall (perf_stall1)
`endif
    );

    // Instruction memory: word = address ^ key, one cycle after the request.
    logic [31:0] key = 32'h0;
    always @(posedge clk) begin
        bus0.imem_rdata <= bus0.imem_req ? (bus0.imem_addr ^ key) : 32'hDEAD_BEEF;
        bus1.imem_rdata <= bus1.imem_req ? bus1.imem_addr : 32'hDEAD_BEEF;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream-level reference: occ = words requested since last flush not yet consumed.
    bit          track = 0;
    bit          scramble = 0;
    int          occ = 0;
    bit          infl_m = 0;
    logic [31:0] req_pc_m = RPC0;
    logic [31:0] exp_pc = RPC0;

    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit r);
        bit exp_req, exp_vld, pop;
        @(posedge clk); #1;
        rst = r;
        bus0.out_ready = rdy;
        bus0.redirect_valid = rv;
        bus0.redirect_pc = rpc;
        #1;
        if (track) begin
            exp_req = !r && !rv && (occ < DEPTH);
            exp_vld = (occ - int'(infl_m)) > 0;
            pop = exp_vld && rdy;
            chk("imem_req", 32'(bus0.imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", bus0.imem_addr, req_pc_m);
            chk("out_valid", 32'(bus0.out_valid), 32'(exp_vld));
            if (pop) begin
                chk("out_pc", bus0.out_pc, exp_pc);
                chk("out_instr", bus0.out_instr, exp_pc ^ key);
                exp_pc = exp_pc + 32'd4;
            end
            if (rv) begin
                occ = 0;
                infl_m = 0;
                req_pc_m = rpc & ~32'd3;
                exp_pc = rpc & ~32'd3;
            end else begin
                occ = occ + int'(exp_req) - int'(pop);
                infl_m = exp_req;
                if (exp_req) req_pc_m = req_pc_m + 32'd4;
            end
        end
        if (r) begin
            track = 1;
            occ = 0;
            infl_m = 0;
            req_pc_m = RPC0;
            exp_pc = RPC0;
            if (scramble) key = $urandom;
        end
    endtask

    initial begin
        bit seen;
        int nreq;
        bus1.out_ready = 1'b1;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc = 32'h0;
        bus0.out_ready = 1'b1;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc = 32'h0;

        // Reset values and free-running stream with word = address.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("rst out_valid", 32'(bus0.out_valid), 32'h0);
        chk("rst out_instr", bus0.out_instr, 32'h0);
        chk("rst out_pc", bus0.out_pc, 32'h0);
        chk("rst imem_req", 32'(bus0.imem_req), 32'h0);
        chk("rst imem_addr", bus0.imem_addr, RPC0);
        chk("rst imem_addr1", bus1.imem_addr, RPC1);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0);
            if (i == 0) begin
                chk("R req", 32'(bus0.imem_req), 32'h1);
                chk("R addr", bus0.imem_addr, 32'h0);
            end
            if (i == 1) chk("R+1 valid", 32'(bus0.out_valid), 32'h0);
            if (i >= 2) begin
                chk("seq out_pc", bus0.out_pc, 32'((i - 2) * 4));
                chk("seq instr=pc", bus0.out_instr, 32'((i - 2) * 4));
                chk("wrap out_pc", bus1.out_pc, RPC1 + 32'((i - 2) * 4));
                chk("wrap valid", 32'(bus1.out_valid), 32'h1);
            end
        end
        scramble = 1;

        // Stall from reset: exactly four requests, then drain and resume at 16.
        step(0, 0, 0, 1);
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            if (bus0.imem_req) begin
                chk("stall addr", bus0.imem_addr, 32'(nreq * 4));
                nreq++;
            end
        end
        chk("stall nreq", 32'(nreq), 32'd4);
        chk("stall req off", 32'(bus0.imem_req), 32'h0);
        chk("stall hold pc", bus0.out_pc, 32'h0);
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            step(1, 0, 0, 0);
            chk("drain out_pc", bus0.out_pc, 32'(j * 4));
            if (bus0.imem_req && !seen) begin
                seen = 1;
                chk("resume addr", bus0.imem_addr, 32'd16);
            end
        end
        chk("resume seen", 32'(seen), 32'h1);

        // Redirect with buffered entries and a request in flight.
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("pre-redir valid", 32'(bus0.out_valid), 32'h1);
        step(0, 1, 32'h0000_0103, 0);
        chk("redir no req", 32'(bus0.imem_req), 32'h0);
        step(0, 0, 0, 0);
        chk("redir T+1 addr", bus0.imem_addr, 32'h100);
        chk("redir T+1 req", 32'(bus0.imem_req), 32'h1);
        step(1, 0, 0, 0);
        chk("redir T+2 valid", 32'(bus0.out_valid), 32'h0);
        step(1, 0, 0, 0);
        chk("redir T+3 out_pc", bus0.out_pc, 32'h100);
        step(1, 0, 0, 0);
        chk("redir T+4 out_pc", bus0.out_pc, 32'h104);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);

        // Back-to-back redirects: last one wins.
        step(1, 1, 32'h0000_2000, 0);
        step(1, 1, 32'h0000_3000, 0);
        step(1, 0, 0, 0);
        chk("b2b addr", bus0.imem_addr, 32'h3000);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("b2b out_pc", bus0.out_pc, 32'h3000);

        // One-cycle reset with a full FIFO; key change exposes stale words.
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        chk("full req off", 32'(bus0.imem_req), 32'h0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("post-rst valid", 32'(bus0.out_valid), 32'h0);
        chk("post-rst addr", bus0.imem_addr, RPC0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("post-rst out_pc", bus0.out_pc, RPC0);
        chk("post-rst instr", bus0.out_instr, RPC0 ^ key);

        // Random ready / redirect / reset traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(($urandom_range(9) < 7), ($urandom_range(19) == 0), tgt, ($urandom_range(99) == 0));
        end

`ifdef FETCH_PERF_EN
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("perf rst fetched", perf_fetched0, 32'h0);
        chk("perf rst stall", perf_stall0, 32'h0);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("perf fetched", perf_fetched0, 32'd10);
        chk("perf stall", perf_stall0, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
